// File: rtl/mem2p_dxw_be_init.sv
// mem2p_dxw_be_init
//   Two-port (one read, one write) synchronous RAM of DEPTH x WIDTH words on a
//   single clock. It has per-lane write enables and a read latency of 1 or 2
//   cycles. A read and write to the same address in the same cycle can bypass
//   the new data to the read. After reset, a hardware sweep writes INIT_VAL
//   into every word, and the user ports are ignored while the sweep runs.
//
// Ports
//   clk      in   1      clock, all state on the rising edge
//   rst      in   1      synchronous active-high reset; restarts the init sweep
//   addrr    in   A      read address
//   addrw    in   A      write address
//   din      in   WIDTH  write data
//   wbe      in   NL     lane write enables, bit i covers din[i*LANEW +: LANEW]
//   mer      in   1      read enable
//   mew      in   1      write enable
//   dout     out  WIDTH  read data, held between completed reads
//   dout_vld out  1      high for one cycle when dout carries a completed read
//   busy     out  1      init sweep in progress
module mem2p_dxw_be_init #(
   parameter int                 DEPTH    = 2048,
   parameter int                 WIDTH    = 24,
   parameter int                 LANEW    = 8,
   parameter int                 RD_LAT   = 1,
   parameter int                 BYPASS   = 1,
   parameter logic [WIDTH-1:0]   INIT_VAL = '0,
   localparam int                NL       = (WIDTH + LANEW - 1) / LANEW,
   localparam int                A        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [A-1:0]     addrr,
   input  logic [A-1:0]     addrw,
   input  logic [WIDTH-1:0] din,
   input  logic [NL-1:0]    wbe,
   input  logic             mer,
   input  logic             mew,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   output logic             busy
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [A-1:0] LAST_ADDR = A'(DEPTH - 1);
   localparam logic [A:0]   DEPTH_W   = (A + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state_q;
   logic [A-1:0]     cnt_q;
   logic             busy_q;

   logic             rd_in_range;
   logic             wr_in_range;
   logic             rd_acc;
   logic             wr_acc;
   logic [WIDTH-1:0] lane_mask;
   logic [WIDTH-1:0] rd_old;
   logic [WIDTH-1:0] rd_word_d;
   logic [WIDTH-1:0] dout_q;
   logic             vld_q;

   // Only a non-power-of-2 depth can see addresses past the last word.
   if ((1 << A) == DEPTH) begin : g_pow2
      assign rd_in_range = 1'b1;
      assign wr_in_range = 1'b1;
   end else begin : g_npow2
      assign rd_in_range = ({1'b0, addrr} < DEPTH_W);
      assign wr_in_range = ({1'b0, addrw} < DEPTH_W);
   end

   // Init sweep FSM: INIT walks cnt_q from 0 to DEPTH-1, then RUN is terminal.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + A'(1);
               end
            end
            default: begin
               state_q <= ST_RUN;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

   // Expand lane enables to a per-bit mask; the last lane may be partial.
   always_comb begin
      lane_mask = '0;
      for (int b = 0; b < WIDTH; b++) begin
         lane_mask[b] = wbe[b / LANEW];
      end
   end

   assign rd_acc = !rst && (state_q == ST_RUN) && mer;
   assign wr_acc = !rst && (state_q == ST_RUN) && mew && wr_in_range;

   // Old word as seen before this edge; out-of-range reads return zero.
   always_comb begin
      rd_old = '0;
      if (rd_in_range) begin
         rd_old = mem[addrr];
      end
   end

   always_comb begin
      rd_word_d = rd_old;
      if ((BYPASS != 0) && wr_acc && (addrw == addrr)) begin
         rd_word_d = (rd_old & ~lane_mask) | (din & lane_mask);
      end
   end

   // Storage: the init sweep has priority; user writes only in RUN.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == ST_INIT)) begin
         mem[cnt_q] <= INIT_VAL;
      end else if (wr_acc) begin
         for (int b = 0; b < WIDTH; b++) begin
            if (lane_mask[b]) begin
               mem[addrw][b] <= din[b];
            end
         end
      end
   end

   if (RD_LAT == 1) begin : g_lat1
      // Output stage
      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= rd_acc;
            if (rd_acc) begin
               dout_q <= rd_word_d;
            end
         end
      end
   end else if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data_q;
      logic             s1_vld_q;

      // Stage 1
      always_ff @(posedge clk) begin
         if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
         end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
               s1_data_q <= rd_word_d;
            end
         end
      end

      // Output stage
      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               dout_q <= s1_data_q;
            end
         end
      end
   end else begin : g_bad_lat
      $error("mem2p_dxw_be_init: RD_LAT must be 1 or 2");
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;

endmodule
